bht_update_ctrl: RTL and testbench
==================================

// Module: bht_update_ctrl
// PURPOSE
//  Controller in front of btb_data_array: owns its read/write ports. Serves fetch-stage
//  direction lookups through the combinational read port. Buffers execute-stage branch
//  resolutions in a small queue, then retires each as a read-modify-write of a
//  WIDTH-bit saturating counter. Sweeps the whole array to INIT_CTR after reset.
// PARAMETERS
//  SIZE    256    counter entries; IDX_W = $clog2(SIZE)
//  WIDTH   2      counter width (must match array width)
//  QDEPTH  4      resolve-queue entries (power of 2)
//  PC_W    32     PC width; index = pc[IDX_W+1:2]
// PORTS
//  clk            in   1      clock
//  rst_n          in   1      async active-low reset
//  lookup_valid   in   1      fetch lookup request
//  lookup_pc      in   PC_W   fetch PC
//  lookup_ready   out  1      lookup accepted this cycle
//  pred_taken     out  1      arr_dataout[WIDTH-1]; valid when lookup_valid&lookup_ready
//  resolve_valid  in   1      branch resolved
//  resolve_pc     in   PC_W   resolved branch PC
//  resolve_taken  in   1      actual direction
//  resolve_ready  out  1      queue can accept (!full)
//  init_done      out  1      sweep complete
//  arr_rindex     out  IDX_W  array read index
//  arr_windex     out  IDX_W  array write index
//  arr_write_en   out  1      array write enable
//  arr_datain     out  WIDTH  array write data
//  arr_dataout    in   WIDTH  array read data; equals arr_datain whenever arr_write_en=1
// BEHAVIOUR
//  - Reset is asynchronous and active-low:
//    - state=INIT, sweep cnt=0, queue empty, init_done=0.
//    - lookup_ready=0, resolve_ready=0.
//    - arr_write_en=1 during reset: repeated benign write of INIT_CTR to index 0.
//  - States: INIT, IDLE, RD, WR.
//  - INIT: arr_write_en=1, windex=cnt, datain=INIT_CTR(2'b10); cnt++ each clk.
//    - After cnt==SIZE-1 -> IDLE, init_done=1 (stays 1 until reset).
//    - Takes SIZE cycles. Both ready outputs are 0; inputs are ignored.
//  - IDLE: arr_write_en=0, rindex=lookup index.
//    - lookup_ready = (count!=QDEPTH).
//    - Queue nonempty & (!lookup_valid | count==QDEPTH) -> RD.
//  - RD: rindex=head index, lookup_ready=0; register arr_dataout into ctr_q; -> WR.
//  - WR: arr_write_en=1, windex=head index, datain=sat(ctr_q, head.taken).
//    - Pop head; lookup_ready=0; -> IDLE.
//  - Update latency is 2 cycles. The read and the write are never in the same cycle:
//    the array bypasses datain to dataout, so a same-cycle read would form a loop.
//  - sat: taken -> (ctr==MAX)?MAX:ctr+1; not taken -> (ctr==0)?0:ctr-1; MAX = 2^WIDTH-1.
//  - Enqueue when resolve_valid & resolve_ready; entry = {index, taken}.
//    - Enqueue and WR pop in the same cycle: count unchanged.
//    - resolve_ready comes from registered count (no pop bypass).
//    - It stays 0 when full, even if a pop is in progress.
//  - Entries retire in FIFO order. Same-index entries each apply in turn (no merging).
//  - Lookups hitting an index with a pending update return the pre-update counter.
//    Accepted: the prediction is a hint.
//  - Reset mid-operation (any state):
//    - queue contents are discarded; a partial RD/WR is abandoned.
//    - sweep restarts at index 0.
// STRUCTURE
//  - bp_pkg:
//    - IDX_W function; INIT_CTR.
//    - state_e enum {INIT, IDLE, RD, WR}.
//    - bp_upd_t struct {idx, taken}.
//    - sat_ctr() function.
//  - Sub-module bp_update_fifo: QDEPTH x bp_upd_t.
//    - Ports push/pop/head/count/full/empty; async active-low reset.
//  - Top holds the FSM, sweep counter, ctr_q and array-port muxing.
// TESTING
//  1. rst_n low 3 clk, release:
//     - exactly 256 writes, windex 0..255, datain=2'b10.
//     - init_done=1 on the next cycle; lookup_ready and resolve_ready both 1.
//  2. Resolve pc=0x40 taken, lookup_valid=0:
//     - RD rindex=0x10, then WR windex=0x10 datain=2'b11.
//     - A later lookup pc=0x40 gives pred_taken=1.
//  3. Saturation at idx 5:
//     - 3 taken -> writes 11,11,11.
//     - 4 not-taken -> 10,01,00,00.
//  4. lookup_valid held 1, 4 resolves queued:
//     - resolve_ready=0 and lookup_ready=0.
//     - One RD/WR drains a single entry; then lookup_ready=1 and resolve_ready=1.
//  5. Queue full, resolve_valid=1 during WR:
//     - no enqueue that cycle; enqueue next cycle; count back to 4.
//  6. rst_n pulsed low in WR with 3 entries queued:
//     - no further write of the queued entry.
//     - Sweep restarts at windex 0; queue empty after INIT.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch history table update controller.
// Counter encoding: 0 = strongly not-taken ... 2^WIDTH-1 = strongly taken.
package bp_pkg;

  localparam int MAX_IDX_W = 16;

  // Weakly-taken starting value for the default 2-bit counter.
  localparam logic [1:0] INIT_CTR = 2'b10;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    RD,
    WR
  } state_e;

  typedef struct packed {
    logic [MAX_IDX_W-1:0] idx;
    logic                 taken;
  } bp_upd_t;

  function automatic int idx_w(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

  // Weakly-taken value for an arbitrary counter width (MSB set, rest clear).
  function automatic logic [31:0] init_ctr(input int width);
    return 32'd1 << (width - 1);
  endfunction

  function automatic logic [31:0] sat_ctr(input logic [31:0] ctr, input logic taken,
                                          input int width);
    logic [31:0] max_v;
    max_v = (32'd1 << width) - 32'd1;
    if (taken) begin
      return (ctr == max_v) ? max_v : ctr + 32'd1;
    end
    return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
  endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// Small FIFO of pending counter updates (index + resolved direction).
// Push while full and pop while empty are ignored.
module bp_update_fifo
  import bp_pkg::*;
#(
  parameter  int QDEPTH = 4,
  localparam int PTR_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1,
  localparam int CNT_W  = $clog2(QDEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  bp_upd_t          push_data,
  input  logic             pop,
  output bp_upd_t          head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  bp_upd_t          mem [QDEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(QDEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because QDEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/bht_update_ctrl.sv
// Owns the BHT array ports: serves fetch lookups, queues branch resolutions and
// retires them as read-modify-write counter updates; sweeps the array after reset.
module bht_update_ctrl
  import bp_pkg::*;
#(
  parameter  int SIZE   = 256,
  parameter  int WIDTH  = 2,
  parameter  int QDEPTH = 4,
  parameter  int PC_W   = 32,
  localparam int IDX_W  = idx_w(SIZE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lookup_valid,
  input  logic [PC_W-1:0]  lookup_pc,
  output logic             lookup_ready,
  output logic             pred_taken,
  input  logic             resolve_valid,
  input  logic [PC_W-1:0]  resolve_pc,
  input  logic             resolve_taken,
  output logic             resolve_ready,
  output logic             init_done,
  output logic [IDX_W-1:0] arr_rindex,
  output logic [IDX_W-1:0] arr_windex,
  output logic             arr_write_en,
  output logic [WIDTH-1:0] arr_datain,
  input  logic [WIDTH-1:0] arr_dataout
);

  localparam int               CNT_W    = $clog2(QDEPTH + 1);
  localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(init_ctr(WIDTH));

  state_e           state;
  state_e           next_state;
  logic [IDX_W-1:0] sweep_cnt;
  logic [WIDTH-1:0] ctr_q;

  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] resolve_idx;
  logic [IDX_W-1:0] head_idx;
  bp_upd_t          push_data;
  bp_upd_t          head;
  logic             q_push;
  logic             q_pop;
  logic [CNT_W-1:0] q_count;
  logic             q_full;
  logic             q_empty;
  logic             unused_bits;

  assign lookup_idx  = lookup_pc[IDX_W+1:2];
  assign resolve_idx = resolve_pc[IDX_W+1:2];
  assign head_idx    = head.idx[IDX_W-1:0];
  assign unused_bits = ^{lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0],
                         resolve_pc[PC_W-1:IDX_W+2], resolve_pc[1:0],
                         head.idx[MAX_IDX_W-1:IDX_W]};

  assign push_data.idx   = MAX_IDX_W'(resolve_idx);
  assign push_data.taken = resolve_taken;

  // Acceptance uses the registered occupancy only, so a pop in flight never opens a slot early.
  assign resolve_ready = (state != INIT) && !q_full;
  assign q_push        = resolve_valid && resolve_ready;
  assign pred_taken    = arr_dataout[WIDTH-1];

  bp_update_fifo #(
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (q_push),
    .push_data (push_data),
    .pop       (q_pop),
    .head      (head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      sweep_cnt <= '0;
      init_done <= 1'b0;
      ctr_q     <= '0;
    end else begin
      state <= next_state;
      if (state == INIT) sweep_cnt <= sweep_cnt + IDX_W'(1);
      if ((state == INIT) && (next_state == IDLE)) init_done <= 1'b1;
      if (state == RD) ctr_q <= arr_dataout;
    end
  end

  // Read and write of an update sit in separate cycles: the array forwards datain to
  // dataout, so reading the head while writing it would close a combinational loop.
  always_comb begin
    next_state   = state;
    lookup_ready = 1'b0;
    arr_rindex   = lookup_idx;
    arr_windex   = sweep_cnt;
    arr_write_en = 1'b0;
    arr_datain   = INIT_VAL;
    q_pop        = 1'b0;
    case (state)
      INIT: begin
        arr_write_en = 1'b1;
        if (sweep_cnt == IDX_W'(SIZE - 1)) next_state = IDLE;
      end
      IDLE: begin
        lookup_ready = (q_count != CNT_W'(QDEPTH));
        if (!q_empty && (!lookup_valid || (q_count == CNT_W'(QDEPTH)))) next_state = RD;
      end
      RD: begin
        arr_rindex = head_idx;
        next_state = WR;
      end
      WR: begin
        arr_write_en = 1'b1;
        arr_windex   = head_idx;
        arr_datain   = WIDTH'(sat_ctr(32'(ctr_q), head.taken, WIDTH));
        q_pop        = 1'b1;
        next_state   = IDLE;
      end
      default: next_state = INIT;
    endcase
  end

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Directed bench for bht_update_ctrl with a behavioural model of the counter array.
module tb_bht_update_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        lookup_ready;
  logic        pred_taken;
  logic        resolve_valid;
  logic [31:0] resolve_pc;
  logic        resolve_taken;
  logic        resolve_ready;
  logic        init_done;
  logic [7:0]  arr_rindex;
  logic [7:0]  arr_windex;
  logic        arr_write_en;
  logic [1:0]  arr_datain;
  logic [1:0]  arr_dataout;

  logic [1:0]  mem [256];
  logic [7:0]  wlog_idx [$];
  logic [1:0]  wlog_dat [$];

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  bht_update_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .lookup_valid  (lookup_valid),
    .lookup_pc     (lookup_pc),
    .lookup_ready  (lookup_ready),
    .pred_taken    (pred_taken),
    .resolve_valid (resolve_valid),
    .resolve_pc    (resolve_pc),
    .resolve_taken (resolve_taken),
    .resolve_ready (resolve_ready),
    .init_done     (init_done),
    .arr_rindex    (arr_rindex),
    .arr_windex    (arr_windex),
    .arr_write_en  (arr_write_en),
    .arr_datain    (arr_datain),
    .arr_dataout   (arr_dataout)
  );

  // Array model: synchronous write, combinational read with write-data bypass.
  always @(posedge clk) begin
    if (arr_write_en === 1'b1) mem[arr_windex] <= arr_datain;
  end
  assign arr_dataout = (arr_write_en === 1'b1) ? arr_datain : mem[arr_rindex];

  always @(negedge clk) begin
    if (arr_write_en === 1'b1) begin
      wlog_idx.push_back(arr_windex);
      wlog_dat.push_back(arr_datain);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic clear_log();
    wlog_idx.delete();
    wlog_dat.delete();
  endtask

  task automatic send_resolve(input logic [31:0] pc, input logic tk);
    int guard;
    @(posedge clk); #1;
    resolve_valid = 1'b1;
    resolve_pc    = pc;
    resolve_taken = tk;
    guard = 0;
    while (resolve_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) begin
      total_cnt++;
      $display("[TB] FAIL resolve_accept_timeout: got ready=%b, expected 1", resolve_ready);
    end
    @(posedge clk); #1;
    resolve_valid = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    int bad;
    rst_n = 1'b0;
    lookup_valid = 1'b0;
    lookup_pc = '0;
    resolve_valid = 1'b0;
    resolve_pc = '0;
    resolve_taken = 1'b0;
    @(negedge clk);
    if (init_done !== 1'b0) begin total_cnt++; $display("[TB] FAIL rst_init_done: got %b, expected 0", init_done); end
    else begin total_cnt++; pass_cnt++; end
    if ({lookup_ready, resolve_ready} !== 2'b00) begin
      total_cnt++; $display("[TB] FAIL rst_ready: got %b, expected 00", {lookup_ready, resolve_ready});
    end else begin total_cnt++; pass_cnt++; end
    if ({arr_write_en, arr_windex, arr_datain} !== {1'b1, 8'h00, 2'b10}) begin
      total_cnt++;
      $display("[TB] FAIL rst_write: got we=%b idx=%0h d=%b, expected we=1 idx=0 d=10",
               arr_write_en, arr_windex, arr_datain);
    end else begin total_cnt++; pass_cnt++; end
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    clear_log();
    n = 0;
    do begin @(negedge clk); n++; end while (init_done !== 1'b1 && n < 400);
    if (n !== 257) begin total_cnt++; $display("[TB] FAIL init_latency: got %0d cycles, expected 257", n); end
    else begin total_cnt++; pass_cnt++; end
    if (wlog_idx.size() !== 256) begin
      total_cnt++; $display("[TB] FAIL sweep_writes: got %0d, expected 256", wlog_idx.size());
    end else begin total_cnt++; pass_cnt++; end
    bad = -1;
    for (int i = 0; i < wlog_idx.size() && i < 256; i++)
      if (bad < 0 && (wlog_idx[i] !== 8'(i) || wlog_dat[i] !== 2'b10)) bad = i;
    if (bad !== -1) begin
      total_cnt++;
      $display("[TB] FAIL sweep_order: entry %0d got idx=%0h d=%b, expected idx=%0h d=10",
               bad, wlog_idx[bad], wlog_dat[bad], bad);
    end else begin total_cnt++; pass_cnt++; end
    if ({lookup_ready, resolve_ready} !== 2'b11) begin
      total_cnt++; $display("[TB] FAIL post_init_ready: got %b, expected 11", {lookup_ready, resolve_ready});
    end else begin total_cnt++; pass_cnt++; end
  endtask

  task automatic test_single_update();
    clear_log();
    send_resolve(32'h40, 1'b1);
    @(negedge clk);
    if (arr_write_en !== 1'b0) begin total_cnt++; $display("[TB] FAIL upd_idle_we: got %b, expected 0", arr_write_en); end
    else begin total_cnt++; pass_cnt++; end
    @(negedge clk);
    if ({arr_write_en, arr_rindex, lookup_ready} !== {1'b0, 8'h10, 1'b0}) begin
      total_cnt++;
      $display("[TB] FAIL upd_rd: got we=%b ridx=%0h lr=%b, expected we=0 ridx=10 lr=0",
               arr_write_en, arr_rindex, lookup_ready);
    end else begin total_cnt++; pass_cnt++; end
    @(negedge clk);
    if ({arr_write_en, arr_windex, arr_datain} !== {1'b1, 8'h10, 2'b11}) begin
      total_cnt++;
      $display("[TB] FAIL upd_wr: got we=%b widx=%0h d=%b, expected we=1 widx=10 d=11",
               arr_write_en, arr_windex, arr_datain);
    end else begin total_cnt++; pass_cnt++; end
    @(posedge clk); #1;
    lookup_valid = 1'b1;
    lookup_pc    = 32'h40;
    @(negedge clk);
    if ({lookup_ready, pred_taken} !== 2'b11) begin
      total_cnt++; $display("[TB] FAIL lookup_after_upd: got ready/pred=%b, expected 11", {lookup_ready, pred_taken});
    end else begin total_cnt++; pass_cnt++; end
    @(posedge clk); #1;
    lookup_valid = 1'b0;
  endtask

  task automatic test_saturation();
    logic [1:0] exp_d [7];
    int n;
    int bad;
    exp_d = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00};
    clear_log();
    for (int i = 0; i < 3; i++) send_resolve(32'h14, 1'b1);
    for (int i = 0; i < 4; i++) send_resolve(32'h14, 1'b0);
    n = 0;
    while (wlog_idx.size() < 7 && n < 100) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    if (wlog_idx.size() !== 7) begin
      total_cnt++; $display("[TB] FAIL sat_write_count: got %0d, expected 7", wlog_idx.size());
    end else begin total_cnt++; pass_cnt++; end
    bad = -1;
    for (int i = 0; i < 7 && i < wlog_idx.size(); i++)
      if (bad < 0 && (wlog_idx[i] !== 8'h05 || wlog_dat[i] !== exp_d[i])) bad = i;
    if (bad !== -1) begin
      total_cnt++;
      $display("[TB] FAIL sat_sequence: write %0d got idx=%0h d=%b, expected idx=05 d=%b",
               bad, wlog_idx[bad], wlog_dat[bad], exp_d[bad]);
    end else begin total_cnt++; pass_cnt++; end
  endtask

  task automatic test_lookup_priority();
    clear_log();
    @(posedge clk); #1;
    lookup_valid = 1'b1;
    lookup_pc    = 32'h100;
    send_resolve(32'h200, 1'b0);
    send_resolve(32'h200, 1'b1);
    send_resolve(32'h200, 1'b1);
    send_resolve(32'h200, 1'b0);
    @(negedge clk);
    if ({lookup_ready, resolve_ready, arr_write_en} !== 3'b000) begin
      total_cnt++;
      $display("[TB] FAIL full_ready: got lr/rr/we=%b, expected 000", {lookup_ready, resolve_ready, arr_write_en});
    end else begin total_cnt++; pass_cnt++; end
    @(negedge clk);
    chk("prio_rd", {arr_write_en, arr_rindex, lookup_ready}, {1'b0, 8'h80, 1'b0});
    @(negedge clk);
    chk("prio_wr", {arr_write_en, arr_windex, arr_datain, resolve_ready}, {1'b1, 8'h80, 2'b01, 1'b0});
    @(negedge clk);
    chk("prio_after_drain", {arr_write_en, lookup_ready, resolve_ready}, {1'b0, 1'b1, 1'b1});
    @(negedge clk);
    chk("prio_single_drain", 32'(wlog_idx.size()), 32'd1);
  endtask

  task automatic test_full_during_wr();
    send_resolve(32'h204, 1'b1);
    resolve_valid = 1'b1;
    resolve_pc    = 32'h300;
    resolve_taken = 1'b1;
    @(negedge clk);
    chk("full_idle_rr", {2'b00, resolve_ready}, 3'b000);
    @(negedge clk);
    chk("full_rd", {arr_write_en, arr_rindex, resolve_ready}, {1'b0, 8'h80, 1'b0});
    @(negedge clk);
    chk("full_wr_no_enq", {arr_write_en, arr_windex, arr_datain, resolve_ready}, {1'b1, 8'h80, 2'b10, 1'b0});
    @(negedge clk);
    chk("full_after_pop", {arr_write_en, resolve_ready}, 2'b01);
    @(posedge clk); #1;
    resolve_valid = 1'b0;
    @(negedge clk);
    chk("full_again", {lookup_ready, resolve_ready}, 2'b00);
  endtask

  task automatic test_reset_mid_wr();
    int n;
    int bad;
    int busy;
    @(negedge clk);
    chk("pre_reset_rd", {31'd0, arr_write_en}, 32'd0);
    @(posedge clk); #1;
    chk("pre_reset_wr", {31'd0, arr_write_en}, 32'd1);
    clear_log();
    rst_n = 1'b0;
    lookup_valid = 1'b0;
    #1;
    chk("async_rst", {init_done, lookup_ready, resolve_ready, arr_write_en, arr_windex, arr_datain},
        {1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 2'b10});
    #1;
    rst_n = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (init_done !== 1'b1 && n < 400);
    chk("resweep_latency", 32'(n), 32'd257);
    chk("resweep_writes", 32'(wlog_idx.size()), 32'd256);
    bad = -1;
    for (int i = 0; i < wlog_idx.size() && i < 256; i++)
      if (bad < 0 && (wlog_idx[i] !== 8'(i) || wlog_dat[i] !== 2'b10)) bad = i;
    chk("resweep_order", 32'(bad), 32'hFFFF_FFFF);
    chk("resweep_ready", {lookup_ready, resolve_ready}, 2'b11);
    busy = 0;
    repeat (4) begin
      @(negedge clk);
      if (arr_write_en !== 1'b0) busy++;
    end
    chk("queue_flushed", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_update();
    test_saturation();
    test_lookup_priority();
    test_full_during_wr();
    test_reset_mid_wr();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
